inv_linear_iter: RTL

- Inverse Kuznyechik (GOST 34.12-2015) linear transform L^-1 for the decryption datapath; the counterpart of the encoder-side linear stage.
- Computes L^-1 = (R^-1)^16 iteratively over one 128-bit block, UNROLL rounds per clock.
- Sits between the round-key XOR and the inverse S-box stage.
- Uses a valid/ready handshake on both sides, so it can be back-pressured by the decryption round controller.

---
 rtl/kuz_pkg.sv | 43 ++++
 rtl/kuz_inv_r_round.sv | 15 +
 rtl/inv_linear_iter.sv | 104 ++++++++++
 3 files changed

// File: rtl/kuz_pkg.sv
// Shared Kuznyechik linear-layer definitions: GF(2^8) arithmetic, the
// l() combining function and the iterative-stage state encoding.
package kuz_pkg;

    // Reduction polynomial x^8+x^7+x^6+x+1 with the x^8 term implicit.
    localparam logic [7:0] GF_POLY = 8'hC3;

    // Coefficient for a15 first, a0 last.
    localparam logic [7:0] L_COEF [0:15] = '{
        8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
        8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift-and-reduce multiply in GF(2^8).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

    // l(a15..a0); byte a15 sits in bits [127:120].
    function automatic logic [7:0] l_func(input logic [127:0] blk);
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < 16; k++) begin
            acc = acc ^ gf_mul(L_COEF[k], blk[8*(15-k) +: 8]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/kuz_inv_r_round.sv
// One inverse R step: shift the block left by a byte and append l() of the
// block rotated so that the outgoing a15 lands in the coefficient-1 slot.
module kuz_inv_r_round
    import kuz_pkg::*;
(
    input  logic [127:0] block,
    output logic [127:0] result
);

    logic [127:0] rotated;

    assign rotated = {block[119:0], block[127:120]};
    assign result  = {block[119:0], l_func(rotated)};

endmodule

// File: rtl/inv_linear_iter.sv
// Iterative inverse linear transform L^-1 = (R^-1)^16 with valid/ready on
// both sides. UNROLL R^-1 steps are cascaded per clock, so a block spends
// 16/UNROLL cycles in BUSY and one in DONE.
module inv_linear_iter
    import kuz_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_o
);

    localparam int ITER  = 16 / UNROLL;
    localparam int CNT_W = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
            $error("inv_linear_iter: UNROLL must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t           state;
    logic [127:0]     work;
    logic [CNT_W-1:0] cnt;
    logic             rdy_q;
    logic             vld_q;

    // Cascade of UNROLL inverse rounds fed from the working register.
    logic [127:0] stage [0:UNROLL];

    assign stage[0] = work;

    generate
        for (genvar g = 0; g < UNROLL; g++) begin : g_round
            kuz_inv_r_round u_round (
                .block  (stage[g]),
                .result (stage[g+1])
            );
        end
    endgenerate

    // Ready comes from a registered flag in IDLE; in DONE it follows
    // out_ready so the next block can be taken in the output handshake.
    assign in_ready  = rdy_q | (vld_q & out_ready);
    assign out_valid = vld_q;
    assign data_o    = work;

    // Control FSM and working register; reset discards any in-flight block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            rdy_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (in_valid && rdy_q) begin
                        work  <= data_i;
                        cnt   <= '0;
                        rdy_q <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    work <= stage[UNROLL];
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        vld_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        vld_q <= 1'b0;
                        if (in_valid) begin
                            work  <= data_i;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            rdy_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    rdy_q <= 1'b0;
                    vld_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
